// File: rtl/spi_apb_sequencer.sv
// APB master command sequencer: queues write/read commands, issues each as one
// SETUP+ACCESS transfer with a pready timeout, and returns in-order responses.
module spi_apb_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 255,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32
) (
    input  logic                             pclk_i,
    input  logic                             presetn_i,
    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic                             cmd_write_i,
    input  logic [ADDR_W-1:0]                cmd_addr_i,
    input  logic [DATA_W-1:0]                cmd_wdata_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [DATA_W-1:0]                rsp_rdata_o,
    output logic                             rsp_err_o,
    output logic                             rsp_timeout_o,
    output logic                             psel_o,
    output logic                             penable_o,
    output logic                             pwrite_o,
    output logic [ADDR_W-1:0]                paddr_o,
    output logic [DATA_W-1:0]                pwdata_o,
    input  logic [DATA_W-1:0]                prdata_i,
    input  logic                             pready_i,
    input  logic                             pslverr_i,
    output logic                             busy_o,
    output logic [$clog2(CMD_DEPTH+1)-1:0]   cmd_count_o
);

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = $clog2(CMD_DEPTH + 1);
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The abort fires on the TIMEOUT-th low-ready ACCESS cycle, i.e. while the counter still reads TIMEOUT-1.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CMD_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                 state_r;
    logic                   fifo_write_r [CMD_DEPTH];
    logic [ADDR_W-1:0]      fifo_addr_r  [CMD_DEPTH];
    logic [DATA_W-1:0]      fifo_wdata_r [CMD_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_next_s;
    logic                   cmd_ready_r;
    logic                   psel_r;
    logic                   penable_r;
    logic                   pwrite_r;
    logic [ADDR_W-1:0]      paddr_r;
    logic [DATA_W-1:0]      pwdata_r;
    logic [TMO_W-1:0]       tmo_cnt_r;
    logic                   rsp_valid_r;
    logic [DATA_W-1:0]      rsp_rdata_r;
    logic                   rsp_err_r;
    logic                   rsp_timeout_r;
    logic                   push_s;
    logic                   pop_s;
    logic                   abort_s;

    assign push_s  = cmd_valid_i & cmd_ready_r;
    assign pop_s   = (state_r == ST_IDLE) & (count_r != {CNT_W{1'b0}}) & (~rsp_valid_r | rsp_ready_i);
    assign abort_s = (TIMEOUT != 0) & (state_r == ST_ACCESS) & ~pready_i & (tmo_cnt_r == TMO_LAST);

    // Next FIFO occupancy from the push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_next_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_next_s = count_r;
        endcase
    end

    // FIFO pointers, occupancy and registered ready (low whenever the current count is full).
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            cmd_ready_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            count_r     <= count_next_s;
            cmd_ready_r <= (count_next_s != CNT_FULL);
        end
    end

    // Command storage; contents are only meaningful between push and pop.
    always_ff @(posedge pclk_i) begin
        if (push_s) begin
            fifo_write_r[wr_ptr_r] <= cmd_write_i;
            fifo_addr_r[wr_ptr_r]  <= cmd_addr_i;
            fifo_wdata_r[wr_ptr_r] <= cmd_wdata_i;
        end
    end

    // APB transfer FSM with timeout counter and single-entry response register.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_r       <= ST_IDLE;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= {ADDR_W{1'b0}};
            pwdata_r      <= {DATA_W{1'b0}};
            tmo_cnt_r     <= {TMO_W{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_W{1'b0}};
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            if (rsp_valid_r && rsp_ready_i) begin
                rsp_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_r  <= ST_SETUP;
                        psel_r   <= 1'b1;
                        pwrite_r <= fifo_write_r[rd_ptr_r];
                        paddr_r  <= fifo_addr_r[rd_ptr_r];
                        pwdata_r <= fifo_wdata_r[rd_ptr_r];
                    end else begin
                        psel_r <= 1'b0;
                    end
                    penable_r <= 1'b0;
                end
                ST_SETUP: begin
                    state_r   <= ST_ACCESS;
                    penable_r <= 1'b1;
                    tmo_cnt_r <= {TMO_W{1'b0}};
                end
                ST_ACCESS: begin
                    if (pready_i) begin
                        state_r       <= ST_IDLE;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= pwrite_r ? {DATA_W{1'b0}} : prdata_i;
                        rsp_err_r     <= pslverr_i;
                        rsp_timeout_r <= 1'b0;
                    end else if (abort_s) begin
                        state_r       <= ST_IDLE;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        tmo_cnt_r     <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= {DATA_W{1'b0}};
                        rsp_err_r     <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o   = cmd_ready_r;
    assign cmd_count_o   = count_r;
    assign psel_o        = psel_r;
    assign penable_o     = penable_r;
    assign pwrite_o      = pwrite_r;
    assign paddr_o       = paddr_r;
    assign pwdata_o      = pwdata_r;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_rdata_o   = rsp_rdata_r;
    assign rsp_err_o     = rsp_err_r;
    assign rsp_timeout_o = rsp_timeout_r;
    assign busy_o        = (count_r != {CNT_W{1'b0}}) | (state_r != ST_IDLE) | rsp_valid_r;

endmodule
